regwrite_arbiter: RTL and testbench
===================================

Name: regwrite_arbiter

Overview:
Shares the single register-file write port between three writers: the stage-2 memory-load writeback, the ALU result path and the immediate-load path. Load writes have absolute priority because stage 2 cannot be back-pressured. ALU and immediate requesters use valid/ready and alternate round-robin. The block also publishes a per-register pending scoreboard for the issue logic, and a halt/drain sequence that replaces the stage-2 immediate $fatal.

Parameters:
WAIT_LIMIT, 4, consecutive cycles a valid ALU/IMM request may wait ungranted before the sticky starvation flag sets (1..15).

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
load_write  in  1  stage-2 load writeback request, no handshake, always accepted
load_index  in  4  destination register of load
load_data  in  32  already sign/zero-extended load data
alu_valid  in  1  ALU write request
alu_ready  out  1  ALU request granted this cycle
alu_index  in  4  ALU destination register
alu_data  in  32  ALU result
imm_valid  in  1  immediate write request
imm_ready  out  1  immediate request granted this cycle
imm_index  in  4  immediate destination register
imm_data  in  32  fully formed 32-bit immediate value
rf_write  out  1  register-file write strobe, registered
rf_index  out  4  register-file write index, registered
rf_data  out  32  register-file write data, registered
pending  out  16  bit n set while any write to register n is requested or in flight
halt_req  in  1  request orderly halt
halted  out  1  drain complete, no further writes
starved  out  1  sticky, a requester hit WAIT_LIMIT

Behaviour:
- Reset (synchronous, active-high): rf_write=0, rf_index=0, rf_data=0, halted=0, starved=0, round-robin pointer=ALU, both wait counters=0, state=RUN. Reset mid-drain returns to RUN.
- Grant is combinational in the cycle. The write appears on rf_* on the next rising edge (latency 1). alu_ready/imm_ready are combinational from the valids, the state and the pointer. A requester holds valid, index and data stable until it sees ready.
- Priority:
  - load_write=1: load is granted; alu_ready=imm_ready=0.
  - Otherwise, if exactly one of alu/imm is valid, it is granted.
  - If both are valid, the pointer's side is granted. The pointer then moves to the other side.
  - The pointer moves only on an ALU/IMM grant.
- No grant in a cycle: rf_write=0 next cycle; rf_index/rf_data hold their previous values.
- Ordering: no reordering beyond the priority rules. Issue logic must not issue a producer to a register whose pending bit is set. Same-index collisions between concurrent requesters are therefore illegal stimulus.
- pending = OR of: decode(load_index) gated by load_write; decode(alu_index) gated by alu_valid; decode(imm_index) gated by imm_valid; decode(rf_index) gated by rf_write.
- Wait counters (one each for ALU and IMM), 4-bit saturating:
  - +1 each cycle the requester is valid and not granted.
  - Cleared on grant or when valid=0.
  - starved sets when either counter reaches WAIT_LIMIT. It stays set until reset.
- State machine:
  - RUN: normal arbitration. halt_req=1 -> DRAIN.
  - DRAIN: arbitration continues. When load_write=0, alu_valid=0, imm_valid=0 and rf_write=0 in the same cycle -> HALTED.
  - HALTED: halted=1, alu_ready=imm_ready=0, rf_write=0. A load_write in HALTED is dropped. Exit only by reset.
  - halt_req is ignored in DRAIN and HALTED.

Test Plan:
- Reset, then load_write=1, load_index=3, load_data=0xDEADBEEF -> next cycle rf_write=1, rf_index=3, rf_data=0xDEADBEEF. pending[3] is set in both cycles, clear afterwards.
- alu_valid and imm_valid held high for 4 cycles, no load -> grants ALU, IMM, ALU, IMM (pointer starts at ALU). rf_data alternates correspondingly.
- load_write=1 for 5 consecutive cycles with alu_valid=1 and WAIT_LIMIT=4 -> alu_ready=0 throughout. starved=1 after the 4th waiting cycle; ALU is granted in cycle 6 and starved stays 1.
- ALU writes reg 7 while the IMM request for reg 2 waits -> pending=0x0084. Once both writes complete and valids drop -> pending=0x0000.
- halt_req pulsed with IMM request outstanding -> IMM is still written. halted=1 on the cycle after inputs and rf_write are all idle. A later alu_valid gets no ready; a later load_write gives no rf_write.
- Reset asserted in DRAIN with alu_valid=1 -> next cycle state is RUN, rf_write=0, halted=0, starved=0, and the ALU is granted on the following cycle.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// rtl/regwrite_arbiter.sv - register-file write-port arbiter with load priority, ALU/IMM round-robin and halt drain
module regwrite_arbiter #(
  parameter int WAIT_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_write,
  input  logic [3:0]  load_index,
  input  logic [31:0] load_data,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_index,
  input  logic [31:0] alu_data,
  input  logic        imm_valid,
  output logic        imm_ready,
  input  logic [3:0]  imm_index,
  input  logic [31:0] imm_data,
  output logic        rf_write,
  output logic [3:0]  rf_index,
  output logic [31:0] rf_data,
  output logic [15:0] pending,
  input  logic        halt_req,
  output logic        halted,
  output logic        starved
);

  localparam logic [3:0] LIMIT = 4'(WAIT_LIMIT);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t     state;
  logic       ptr_imm;
  logic [3:0] alu_wait;
  logic [3:0] imm_wait;
  logic [3:0] alu_wait_next;
  logic [3:0] imm_wait_next;
  logic       active;
  logic       load_grant;
  logic       alu_grant;
  logic       imm_grant;
  logic       drain_idle;

  // Stage 2 cannot stall, so a load always wins; ALU/IMM only share what is left.
  assign active     = (state != HALTED);
  assign load_grant = active && load_write;
  assign alu_grant  = active && !load_write && alu_valid && (!imm_valid || !ptr_imm);
  assign imm_grant  = active && !load_write && imm_valid && (!alu_valid || ptr_imm);
  assign alu_ready  = alu_grant;
  assign imm_ready  = imm_grant;
  assign drain_idle = !load_write && !alu_valid && !imm_valid && !rf_write;

  always_comb begin
    alu_wait_next = 4'd0;
    imm_wait_next = 4'd0;
    if (alu_valid && !alu_grant)
      alu_wait_next = (alu_wait == 4'hf) ? alu_wait : alu_wait + 4'd1;
    if (imm_valid && !imm_grant)
      imm_wait_next = (imm_wait == 4'hf) ? imm_wait : imm_wait + 4'd1;
  end

  always_comb begin
    pending = 16'h0000;
    if (load_write) pending = pending | (16'h0001 << load_index);
    if (alu_valid)  pending = pending | (16'h0001 << alu_index);
    if (imm_valid)  pending = pending | (16'h0001 << imm_index);
    if (rf_write)   pending = pending | (16'h0001 << rf_index);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      ptr_imm  <= 1'b0;
      alu_wait <= 4'd0;
      imm_wait <= 4'd0;
      rf_write <= 1'b0;
      rf_index <= 4'd0;
      rf_data  <= 32'd0;
      halted   <= 1'b0;
      starved  <= 1'b0;
    end else begin
      rf_write <= load_grant || alu_grant || imm_grant;
      if (load_grant) begin
        rf_index <= load_index;
        rf_data  <= load_data;
      end else if (alu_grant) begin
        rf_index <= alu_index;
        rf_data  <= alu_data;
      end else if (imm_grant) begin
        rf_index <= imm_index;
        rf_data  <= imm_data;
      end

      if (alu_grant)
        ptr_imm <= 1'b1;
      else if (imm_grant)
        ptr_imm <= 1'b0;

      alu_wait <= alu_wait_next;
      imm_wait <= imm_wait_next;
      if (alu_wait_next >= LIMIT || imm_wait_next >= LIMIT)
        starved <= 1'b1;

      case (state)
        RUN: begin
          if (halt_req)
            state <= DRAIN;
        end
        DRAIN: begin
          if (drain_idle) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        default: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb/tb_regwrite_arbiter.sv - scoreboard bench for regwrite_arbiter
module tb_regwrite_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_write;
  logic [3:0]  load_index;
  logic [31:0] load_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_index;
  logic [31:0] alu_data;
  logic        imm_valid;
  logic        imm_ready;
  logic [3:0]  imm_index;
  logic [31:0] imm_data;
  logic        rf_write;
  logic [3:0]  rf_index;
  logic [31:0] rf_data;
  logic [15:0] pending;
  logic        halt_req;
  logic        halted;
  logic        starved;

  int pass_count  = 0;
  int check_count = 0;
  logic [35:0] exp_q[$];

  regwrite_arbiter #(.WAIT_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .load_write(load_write), .load_index(load_index), .load_data(load_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_index(alu_index), .alu_data(alu_data),
    .imm_valid(imm_valid), .imm_ready(imm_ready), .imm_index(imm_index), .imm_data(imm_data),
    .rf_write(rf_write), .rf_index(rf_index), .rf_data(rf_data),
    .pending(pending), .halt_req(halt_req), .halted(halted), .starved(starved)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every rf write must match the oldest expected write.
  always @(negedge clock) begin
    if (rf_write === 1'b1) begin
      check_count++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got idx %0d data 0x%0h expected no write", rf_index, rf_data);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if ({rf_index, rf_data} === e) pass_count++;
        else $display("FAIL rf_write_data: got idx %0d data 0x%0h expected idx %0d data 0x%0h",
                      rf_index, rf_data, e[35:32], e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    load_write = 0; load_index = 0; load_data = 0;
    alu_valid = 0; alu_index = 0; alu_data = 0;
    imm_valid = 0; imm_index = 0; imm_data = 0;
    halt_req = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    check("reset_rf_write", 32'(rf_write), 32'd0);
    check("reset_rf_index", 32'(rf_index), 32'd0);
    check("reset_rf_data", rf_data, 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_starved", 32'(starved), 32'd0);
    check("reset_pending", 32'(pending), 32'd0);

    // Load writeback
    load_write = 1; load_index = 3; load_data = 32'hDEADBEEF;
    exp_q.push_back({4'd3, 32'hDEADBEEF});
    #1 check("load_pending_req", 32'(pending), 32'h0008);
    step();
    load_write = 0;
    #1;
    check("load_rf_write", 32'(rf_write), 32'd1);
    check("load_pending_flight", 32'(pending), 32'h0008);
    step();
    check("load_pending_clear", 32'(pending), 32'h0000);

    // ALU/IMM round-robin, pointer starts at ALU
    do_reset();
    alu_valid = 1; alu_index = 1; alu_data = 32'hA1A1_0001;
    imm_valid = 1; imm_index = 2; imm_data = 32'hB2B2_0002;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_alu_ready", 32'(alu_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_imm_ready", 32'(imm_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k % 2 == 0) exp_q.push_back({4'd1, 32'hA1A1_0001});
      else            exp_q.push_back({4'd2, 32'hB2B2_0002});
      step();
    end
    alu_valid = 0; imm_valid = 0;
    step();

    // Load priority and starvation
    do_reset();
    alu_valid = 1; alu_index = 6; alu_data = 32'h0000_0A06;
    for (int k = 0; k < 5; k++) begin
      load_write = 1; load_index = 5; load_data = 32'h1000_0000 + 32'(k);
      exp_q.push_back({4'd5, 32'h1000_0000 + 32'(k)});
      #1 check("starve_alu_ready", 32'(alu_ready), 32'd0);
      step();
      check("starve_flag", 32'(starved), (k >= 3) ? 32'd1 : 32'd0);
    end
    load_write = 0;
    #1 check("starve_alu_granted", 32'(alu_ready), 32'd1);
    exp_q.push_back({4'd6, 32'h0000_0A06});
    step();
    alu_valid = 0;
    check("starve_sticky", 32'(starved), 32'd1);
    step();
    check("starve_sticky2", 32'(starved), 32'd1);

    // Pending scoreboard
    do_reset();
    alu_valid = 1; alu_index = 7; alu_data = 32'h0000_0707;
    imm_valid = 1; imm_index = 2; imm_data = 32'h0000_0202;
    #1;
    check("pend_both", 32'(pending), 32'h0084);
    check("pend_alu_first", 32'(alu_ready), 32'd1);
    exp_q.push_back({4'd7, 32'h0000_0707});
    step();
    alu_valid = 0;
    #1 check("pend_imm_wait", 32'(pending), 32'h0084);
    exp_q.push_back({4'd2, 32'h0000_0202});
    step();
    imm_valid = 0;
    #1 check("pend_imm_flight", 32'(pending), 32'h0004);
    step();
    check("pend_clear", 32'(pending), 32'h0000);

    // Halt drain
    do_reset();
    imm_valid = 1; imm_index = 9; imm_data = 32'h0000_0909; halt_req = 1;
    #1 check("halt_imm_ready", 32'(imm_ready), 32'd1);
    exp_q.push_back({4'd9, 32'h0000_0909});
    step();
    imm_valid = 0; halt_req = 0;
    check("halt_drain_busy", 32'(halted), 32'd0);
    step();
    check("halt_drain_idle", 32'(halted), 32'd0);
    step();
    check("halt_halted", 32'(halted), 32'd1);
    alu_valid = 1; alu_index = 4; alu_data = 32'h0000_0404;
    #1 check("halt_alu_no_ready", 32'(alu_ready), 32'd0);
    load_write = 1; load_index = 8; load_data = 32'h0000_0808;
    step();
    load_write = 0; alu_valid = 0;
    check("halt_no_write", 32'(rf_write), 32'd0);
    step();
    check("halt_still", 32'(halted), 32'd1);

    // Reset while draining
    do_reset();
    alu_valid = 1; alu_index = 11; alu_data = 32'h0000_0B0B;
    load_write = 1; load_index = 12; load_data = 32'h0000_0C0C; halt_req = 1;
    exp_q.push_back({4'd12, 32'h0000_0C0C});
    step();
    load_write = 0; halt_req = 0; reset = 1;
    step();
    reset = 0;
    check("rst_drain_rf_write", 32'(rf_write), 32'd0);
    check("rst_drain_halted", 32'(halted), 32'd0);
    check("rst_drain_starved", 32'(starved), 32'd0);
    #1 check("rst_drain_alu_ready", 32'(alu_ready), 32'd1);
    exp_q.push_back({4'd11, 32'h0000_0B0B});
    step();
    alu_valid = 0;
    check("rst_drain_write", 32'(rf_write), 32'd1);
    step(); step(); step();
    check("rst_drain_not_halted", 32'(halted), 32'd0);

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
